// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, ALU operation encodings
// and the decoded-control bundle passed from id_decode to the issue stage.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_NAND  = 6'h2C;
   localparam logic [5:0] FN_NOR   = 6'h27;

   typedef enum logic [1:0] {
      ALUOP_ADD  = 2'b00,
      ALUOP_SUB  = 2'b01,
      ALUOP_NAND = 2'b10,
      ALUOP_NOR  = 2'b11
   } aluop_e;

   typedef struct packed {
      aluop_e     aluop;
      logic       use_imm;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic [4:0] rd;
   } ctrl_t;

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder: instruction word -> control bundle,
// illegal flag and which register fields the instruction actually reads.
module id_decode
   import mips_pkg::*;
(
   input  logic [31:0] instr_i,
   output ctrl_t       ctrl_o,
   output logic        illegal_o,
   output logic        use_rs_o,
   output logic        use_rt_o
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       decode_unused;

   assign opcode        = instr_i[31:26];
   assign funct         = instr_i[5:0];
   assign decode_unused = ^{instr_i[25:21], instr_i[10:6]};

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      ctrl_o    = '0;
      illegal_o = 1'b0;
      use_rs_o  = 1'b0;
      use_rt_o  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            use_rs_o        = 1'b1;
            use_rt_o        = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.rd       = instr_i[15:11];
            case (funct)
               FN_ADD:  ctrl_o.aluop = ALUOP_ADD;
               FN_SUB:  ctrl_o.aluop = ALUOP_SUB;
               FN_NAND: ctrl_o.aluop = ALUOP_NAND;
               FN_NOR:  ctrl_o.aluop = ALUOP_NOR;
               default: illegal_o    = 1'b1;
            endcase
         end
         OP_ADDI: begin
            use_rs_o        = 1'b1;
            ctrl_o.use_imm  = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.rd       = instr_i[20:16];
         end
         OP_LW: begin
            use_rs_o        = 1'b1;
            ctrl_o.use_imm  = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.memread  = 1'b1;
            ctrl_o.rd       = instr_i[20:16];
         end
         OP_SW: begin
            use_rs_o        = 1'b1;
            use_rt_o        = 1'b1;
            ctrl_o.use_imm  = 1'b1;
            ctrl_o.memwrite = 1'b1;
         end
         OP_BEQ: begin
            use_rs_o      = 1'b1;
            use_rt_o      = 1'b1;
            ctrl_o.aluop  = ALUOP_SUB;
            ctrl_o.branch = 1'b1;
         end
         default: illegal_o = 1'b1;
      endcase
      // An undefined instruction becomes a bubble, so it must not stall on a load either.
      if (illegal_o) begin
         ctrl_o   = '0;
         use_rs_o = 1'b0;
         use_rt_o = 1'b0;
      end
   end

endmodule

// File: rtl/id_ex_issue.sv
// Decode/issue stage with load-use hazard detection and the ID/EX register.
// Optional WB->ID operand bypass is enabled by defining ID_WB_BYPASS_EN.
module id_ex_issue
   import mips_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_valid,
   output logic               if_ready,
   input  logic [31:0]        if_instr,
   input  logic [XLEN-1:0]    if_pc,
   output logic [RADDR_W-1:0] rs_addr,
   output logic [RADDR_W-1:0] rt_addr,
   input  logic [XLEN-1:0]    rs_data,
   input  logic [XLEN-1:0]    rt_data,
   input  logic               wb_we,
   input  logic [RADDR_W-1:0] wb_addr,
   input  logic [XLEN-1:0]    wb_data,
   input  logic               ex_stall,
   input  logic               flush,
   output logic               ex_valid,
   output logic [1:0]         ex_aluop,
   output logic [XLEN-1:0]    ex_a,
   output logic [XLEN-1:0]    ex_b,
   output logic [XLEN-1:0]    ex_st_data,
   output logic [RADDR_W-1:0] ex_rd,
   output logic               ex_regwrite,
   output logic               ex_memread,
   output logic               ex_memwrite,
   output logic               ex_branch,
   output logic [XLEN-1:0]    ex_pc,
   output logic               illegal
);

   typedef struct packed {
      logic               valid;
      aluop_e             aluop;
      logic [XLEN-1:0]    a;
      logic [XLEN-1:0]    b;
      logic [XLEN-1:0]    st_data;
      logic [RADDR_W-1:0] rd;
      logic               regwrite;
      logic               memread;
      logic               memwrite;
      logic               branch;
      logic [XLEN-1:0]    pc;
   } idex_t;

   idex_t           idex_q, idex_d;
   logic            illegal_q, illegal_d;
   ctrl_t           dec_ctrl;
   logic            dec_illegal, use_rs, use_rt;
   logic            byp_rs, byp_rt;
   logic [XLEN-1:0] rs_val, rt_val, imm_ext;
   logic            hazard, accept;

   id_decode u_decode (
      .instr_i   (if_instr),
      .ctrl_o    (dec_ctrl),
      .illegal_o (dec_illegal),
      .use_rs_o  (use_rs),
      .use_rt_o  (use_rt)
   );

   assign rs_addr = if_instr[25:21];
   assign rt_addr = if_instr[20:16];
   assign imm_ext = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

`ifdef ID_WB_BYPASS_EN
   assign byp_rs = wb_we && (wb_addr == rs_addr) && (wb_addr != '0);
   assign byp_rt = wb_we && (wb_addr == rt_addr) && (wb_addr != '0);
`else
   logic wb_unused;
   assign wb_unused = ^{wb_we, wb_addr, wb_data};
   assign byp_rs    = 1'b0;
   assign byp_rt    = 1'b0;
`endif

   assign rs_val = (rs_addr == '0) ? '0 : (byp_rs ? wb_data : rs_data);
   assign rt_val = (rt_addr == '0) ? '0 : (byp_rt ? wb_data : rt_data);

   assign hazard = idex_q.valid && idex_q.memread && (idex_q.rd != '0) &&
                   ((use_rs && (rs_addr == idex_q.rd)) ||
                    (use_rt && (rt_addr == idex_q.rd)));

   // flush acknowledges the offered instruction so fetch can discard it.
   assign if_ready = !rst && (flush || (!ex_stall && !hazard));
   assign accept   = if_valid && if_ready;

   always_comb begin
      idex_d    = idex_q;
      illegal_d = 1'b0;
      if (flush) begin
         idex_d = '0;
      end else if (!ex_stall) begin
         if (accept && !dec_illegal) begin
            idex_d.valid    = 1'b1;
            idex_d.aluop    = dec_ctrl.aluop;
            idex_d.a        = rs_val;
            idex_d.b        = dec_ctrl.use_imm ? imm_ext : rt_val;
            idex_d.st_data  = rt_val;
            idex_d.rd       = dec_ctrl.rd;
            idex_d.regwrite = dec_ctrl.regwrite;
            idex_d.memread  = dec_ctrl.memread;
            idex_d.memwrite = dec_ctrl.memwrite;
            idex_d.branch   = dec_ctrl.branch;
            idex_d.pc       = if_pc;
         end else begin
            idex_d    = '0;
            illegal_d = accept && dec_illegal;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         idex_q    <= idex_d;
         illegal_q <= illegal_d;
      end
   end

   assign ex_valid    = idex_q.valid;
   assign ex_aluop    = idex_q.aluop;
   assign ex_a        = idex_q.a;
   assign ex_b        = idex_q.b;
   assign ex_st_data  = idex_q.st_data;
   assign ex_rd       = idex_q.rd;
   assign ex_regwrite = idex_q.regwrite;
   assign ex_memread  = idex_q.memread;
   assign ex_memwrite = idex_q.memwrite;
   assign ex_branch   = idex_q.branch;
   assign ex_pc       = idex_q.pc;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Randomized self-checking bench for id_ex_issue against a behavioural model.
// Honours ID_WB_BYPASS_EN the same way the design does.
module tb_id_ex_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [4:0]  rs_addr, rt_addr;
   logic [31:0] rs_data, rt_data;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_stall, flush;
   logic        ex_valid;
   logic [1:0]  ex_aluop;
   logic [31:0] ex_a, ex_b, ex_st_data, ex_pc;
   logic [4:0]  ex_rd;
   logic        ex_regwrite, ex_memread, ex_memwrite, ex_branch;
   logic        illegal;

   id_ex_issue #(.XLEN(32), .RADDR_W(5)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_stall(ex_stall), .flush(flush),
      .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_a(ex_a), .ex_b(ex_b),
      .ex_st_data(ex_st_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
      .ex_pc(ex_pc), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      bit        valid;
      bit [1:0]  aluop;
      bit [31:0] a, b, st, pc;
      bit [4:0]  rd;
      bit        rw, mr, mw, br;
   } ex_t;

   ex_t m;
   bit  m_ill;
   bit  seen_ready;

   function automatic bit [31:0] rtype(input int rs, rt, rd, input bit [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic bit [31:0] itype(input bit [5:0] op, input int rs, rt, input bit [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic bit [31:0] operand(input bit [4:0] a, input bit [31:0] rf,
                                         input bit we, input bit [4:0] wa, input bit [31:0] wd);
      if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
      if (we && wa == a) return wd;
`endif
      return rf;
   endfunction

   // Returns 1 for a defined instruction and fills in what EX should see.
   function automatic bit ref_decode(input bit [31:0] ins, input bit [31:0] rsv, rtv, pc,
                                     output ex_t e, output bit urs, output bit urt);
      bit [31:0] imm;
      imm = {{16{ins[15]}}, ins[15:0]};
      e = '0; urs = 0; urt = 0;
      e.valid = 1; e.a = rsv; e.b = rtv; e.st = rtv; e.pc = pc;
      case (ins[31:26])
         6'h00: begin
            case (ins[5:0])
               6'h20: e.aluop = 2'd0;
               6'h22: e.aluop = 2'd1;
               6'h2C: e.aluop = 2'd2;
               6'h27: e.aluop = 2'd3;
               default: return 0;
            endcase
            urs = 1; urt = 1; e.rw = 1; e.rd = ins[15:11];
         end
         6'h08: begin urs = 1; e.rw = 1; e.b = imm; e.rd = ins[20:16]; end
         6'h23: begin urs = 1; e.rw = 1; e.mr = 1; e.b = imm; e.rd = ins[20:16]; end
         6'h2B: begin urs = 1; urt = 1; e.mw = 1; e.b = imm; end
         6'h04: begin urs = 1; urt = 1; e.aluop = 2'd1; e.br = 1; end
         default: return 0;
      endcase
      return 1;
   endfunction

   task automatic compare_ex(input string pfx);
      check({pfx, "_ex_valid"}, ex_valid, m.valid);
      check({pfx, "_illegal"}, illegal, m_ill);
      if (m.valid) begin
         check({pfx, "_aluop"}, ex_aluop, m.aluop);
         check({pfx, "_a"}, ex_a, m.a);
         check({pfx, "_b"}, ex_b, m.b);
         check({pfx, "_st_data"}, ex_st_data, m.st);
         check({pfx, "_rd"}, ex_rd, m.rd);
         check({pfx, "_ctrl"}, {ex_regwrite, ex_memread, ex_memwrite, ex_branch},
               {m.rw, m.mr, m.mw, m.br});
         check({pfx, "_pc"}, ex_pc, m.pc);
      end
   endtask

   // One clock: drive at negedge, check combinational outputs, step model, check after edge.
   task automatic cycle(input string pfx, input bit v, input bit [31:0] ins, input bit [31:0] pc,
                        input bit [31:0] rsd, rtd, input bit st, fl,
                        input bit wwe, input bit [4:0] wa, input bit [31:0] wd);
      ex_t e;
      bit  legal, urs, urt, hz, rdy;
      @(negedge clk);
      if_valid = v; if_instr = ins; if_pc = pc; rs_data = rsd; rt_data = rtd;
      ex_stall = st; flush = fl; wb_we = wwe; wb_addr = wa; wb_data = wd;
      #1;
      legal = ref_decode(ins, operand(ins[25:21], rsd, wwe, wa, wd),
                         operand(ins[20:16], rtd, wwe, wa, wd), pc, e, urs, urt);
      hz  = m.valid && m.mr && m.rd != 0 &&
            ((urs && ins[25:21] == m.rd) || (urt && ins[20:16] == m.rd));
      rdy = fl || (!st && !hz);
      seen_ready = if_ready;
      check({pfx, "_rs_addr"}, rs_addr, ins[25:21]);
      check({pfx, "_rt_addr"}, rt_addr, ins[20:16]);
      check({pfx, "_if_ready"}, if_ready, rdy);
      m_ill = 0;
      if (fl) m = '0;
      else if (!st) begin
         if (v && rdy && legal) m = e;
         else begin
            m = '0;
            m_ill = v && rdy && !legal;
         end
      end
      @(posedge clk);
      #1;
      compare_ex(pfx);
   endtask

   task automatic idle(input string pfx);
      cycle(pfx, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0);
   endtask

   function automatic bit [31:0] rand_instr();
      int rs, rt, rd;
      rs = $urandom_range(0, 3); rt = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      case ($urandom_range(0, 9))
         0: return rtype(rs, rt, rd, 6'h20);
         1: return rtype(rs, rt, rd, 6'h22);
         2: return rtype(rs, rt, rd, 6'h2C);
         3: return rtype(rs, rt, rd, 6'h27);
         4: return rtype(rs, rt, rd, 6'h3F);
         5: return itype(6'h08, rs, rt, 16'($urandom));
         6: return itype(6'h23, rs, rt, 16'($urandom));
         7: return itype(6'h2B, rs, rt, 16'($urandom));
         8: return itype(6'h04, rs, rt, 16'($urandom));
         default: return itype(6'h3F, rs, rt, 16'($urandom));
      endcase
   endfunction

   initial begin
      rst = 1'b1; if_valid = 0; if_instr = 0; if_pc = 0; rs_data = 0; rt_data = 0;
      wb_we = 0; wb_addr = 0; wb_data = 0; ex_stall = 0; flush = 0;
      m = '0; m_ill = 0;
      #22;
      check("rst_if_ready", if_ready, 0);
      check("rst_ex_valid", ex_valid, 0);
      check("rst_ex_fields", {ex_aluop, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_branch},
            32'd0);
      check("rst_ex_data", ex_a | ex_b | ex_st_data | ex_pc, 32'd0);
      check("rst_illegal", illegal, 0);
      @(negedge clk); rst = 1'b0;

      cycle("add", 1, rtype(1, 2, 3, 6'h20), 32'h100, 32'd5, 32'd7, 0, 0, 0, 5'd0, 32'd0);
      check("add_a_lit", ex_a, 32'd5);
      check("add_b_lit", ex_b, 32'd7);
      check("add_rd_lit", ex_rd, 32'd3);
      check("add_op_lit", ex_aluop, 32'd0);
      check("add_rw_lit", ex_regwrite, 32'd1);

      cycle("addi", 1, itype(6'h08, 1, 4, 16'hFFFF), 32'h104, 32'd5, 32'd0, 0, 0, 0, 5'd0, 32'd0);
      check("addi_b_lit", ex_b, 32'hFFFF_FFFF);
      check("addi_rd_lit", ex_rd, 32'd4);

      cycle("lw", 1, itype(6'h23, 1, 2, 16'h0010), 32'h108, 32'd40, 32'd0, 0, 0, 0, 5'd0, 32'd0);
      cycle("lu1", 1, rtype(2, 1, 5, 6'h20), 32'h10C, 32'd11, 32'd40, 0, 0, 0, 5'd0, 32'd0);
      check("lu_ready_lit", seen_ready, 0);
      check("lu_bubble_lit", ex_valid, 0);
      cycle("lu2", 1, rtype(2, 1, 5, 6'h20), 32'h10C, 32'd11, 32'd40, 0, 0, 0, 5'd0, 32'd0);
      check("lu_issue_lit", ex_valid, 1);
      check("lu_rd_lit", ex_rd, 32'd5);

      for (int i = 0; i < 3; i++) begin
         cycle("stall", 1, rtype(1, 2, 6, 6'h22), 32'h110, 32'd1, 32'd2, 1, 0, 0, 5'd0, 32'd0);
         check("stall_ready_lit", seen_ready, 0);
         check("stall_rd_lit", ex_rd, 32'd5);
      end
      cycle("stflush", 1, rtype(1, 2, 6, 6'h22), 32'h110, 32'd1, 32'd2, 1, 1, 0, 5'd0, 32'd0);
      check("flush_valid_lit", ex_valid, 0);
      check("flush_ready_lit", seen_ready, 1);

      cycle("ill", 1, rtype(1, 2, 3, 6'h3F), 32'h114, 32'd1, 32'd2, 0, 0, 0, 5'd0, 32'd0);
      check("ill_pulse_lit", illegal, 1);
      check("ill_bubble_lit", ex_valid, 0);
      idle("ill_end");
      check("ill_clear_lit", illegal, 0);

      cycle("r0", 1, rtype(0, 1, 6, 6'h20), 32'h118, 32'hDEAD, 32'd3, 0, 0, 0, 5'd0, 32'd0);
      check("r0_a_lit", ex_a, 32'd0);

      cycle("byp", 1, rtype(1, 2, 7, 6'h20), 32'h11C, 32'd2, 32'd3, 0, 0, 1, 5'd1, 32'd9);
`ifdef ID_WB_BYPASS_EN
      check("byp_a_lit", ex_a, 32'd9);
`else
      check("byp_a_lit", ex_a, 32'd2);
`endif

      for (int i = 0; i < 400; i++) begin
         cycle("rnd", $urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
               $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
      end

      cycle("pre_rst", 1, rtype(1, 2, 3, 6'h27), 32'h200, 32'h1234, 32'h5678, 0, 0, 0, 5'd0, 32'd0);
      @(negedge clk);
      ex_stall = 1'b0; flush = 1'b0; if_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", ex_valid, 0);
      check("async_rst_rd", ex_rd, 32'd0);
      check("async_rst_ready", if_ready, 0);
      m = '0; m_ill = 0;
      @(negedge clk); rst = 1'b0;
      idle("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
